// File: rtl/control_pkg.sv
// Shared types for the control sequencer: FSM states, opcodes, condition codes
// and the condition-code evaluation function.
package control_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_FETCH_W, S_DECODE, S_EXEC, S_MADDR,
    S_MRD_W, S_WB, S_SDATA, S_MWR_W, S_HALTED
  } state_e;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ALU  = 4'h1,
    OP_LD   = 4'h2,
    OP_ST   = 4'h3,
    OP_HALT = 4'hF
  } op_e;

  typedef enum logic [3:0] {
    C_AL = 4'h0, C_EQ = 4'h1, C_NE = 4'h2, C_MI = 4'h3, C_PL = 4'h4, C_CS = 4'h5,
    C_CC = 4'h6, C_VS = 4'h7, C_VC = 4'h8, C_GE = 4'h9, C_LT = 4'hA
  } cond_e;

  // flags = {N,Z,C,V}; codes B..F never pass
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] flags);
    logic n, z, c, v;
    {n, z, c, v} = flags;
    case (cond)
      C_AL:    return 1'b1;
      C_EQ:    return z;
      C_NE:    return !z;
      C_MI:    return n;
      C_PL:    return !n;
      C_CS:    return c;
      C_CC:    return !c;
      C_VS:    return v;
      C_VC:    return !v;
      C_GE:    return n == v;
      C_LT:    return n != v;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/control_seq_if.sv
// Bundle between the sequencer and the datapath: IR/status/handshake inputs
// and all bus-enable and load strobes.
interface control_seq_if #(
  parameter int REG_SEL_W = 4,
  parameter int ALU_OP_W  = 4,
  parameter int STATUS_W  = 4
);
  logic [31:0]          ir;
  logic [STATUS_W-1:0]  status;
  logic                 mem_ready;
  logic                 run;
  logic                 mem_rd, mem_wr;
  logic                 oe_a_reg_file, oe_b_reg_file, ld_reg_file;
  logic [REG_SEL_W-1:0] sel_a_reg_file, sel_b_reg_file, sel_ld_reg_file;
  logic                 inc_pc, ld_ir, ld_status, oe_mdr, ld_mdr, oe_mar, ld_mar, oe_alu;
  logic [ALU_OP_W-1:0]  alu_op;
  logic                 halted, fault;

  modport master (
    input  ir, status, mem_ready, run,
    output mem_rd, mem_wr, oe_a_reg_file, oe_b_reg_file, ld_reg_file,
           sel_a_reg_file, sel_b_reg_file, sel_ld_reg_file,
           inc_pc, ld_ir, ld_status, oe_mdr, ld_mdr, oe_mar, ld_mar, oe_alu,
           alu_op, halted, fault
  );

  modport slave (
    output ir, status, mem_ready, run,
    input  mem_rd, mem_wr, oe_a_reg_file, oe_b_reg_file, ld_reg_file,
           sel_a_reg_file, sel_b_reg_file, sel_ld_reg_file,
           inc_pc, ld_ir, ld_status, oe_mdr, ld_mdr, oe_mar, ld_mar, oe_alu,
           alu_op, halted, fault
  );
endinterface

// File: rtl/cond_eval.sv
// Combinational condition-code check: status flags {N,Z,C,V} against IR cond.
module cond_eval
  import control_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);
  assign pass = cond_pass(cond, flags);
endmodule

// File: rtl/control_seq.sv
// Multi-cycle control sequencer: decodes the IR and sequences datapath strobes,
// memory wait states with timeout, load/store, and halt/resume with fault.
module control_seq
  import control_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int PC_REG   = NUM_REGS - 1,
  parameter int ALU_OP_W = 4,
  parameter int STATUS_W = 4,
  parameter int WAIT_MAX = 16
) (
  input logic            clk,
  input logic            rst_n,
  control_seq_if.master  bus
);
  localparam int REG_SEL_W = $clog2(NUM_REGS);
  localparam int AOP_LSB   = 24 - ALU_OP_W;
  localparam int RD_LSB    = AOP_LSB - REG_SEL_W;
  localparam int RA_LSB    = RD_LSB - REG_SEL_W;
  localparam int RB_LSB    = RA_LSB - REG_SEL_W;
  localparam int WCNT_W    = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam logic [WCNT_W-1:0] WCNT_LIM = WCNT_W'((WAIT_MAX > 0) ? WAIT_MAX - 1 : 0);
  localparam logic [REG_SEL_W-1:0] PC_SEL = REG_SEL_W'(PC_REG);

  state_e              state_q, state_d;
  logic                fault_q, fault_d;
  logic [WCNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                pass, timeout;

  logic [3:0]           op;
  logic [ALU_OP_W-1:0]  aop;
  logic [REG_SEL_W-1:0] rd, ra, rb;
  logic                 unused_ir_bits;

  assign op  = bus.ir[27:24];
  assign aop = bus.ir[23:AOP_LSB];
  assign rd  = bus.ir[AOP_LSB-1:RD_LSB];
  assign ra  = bus.ir[RD_LSB-1:RA_LSB];
  assign rb  = bus.ir[RA_LSB-1:RB_LSB];
  assign unused_ir_bits = ^bus.ir[RB_LSB-1:0];

  cond_eval u_cond (.cond(bus.ir[31:28]), .flags(bus.status[3:0]), .pass(pass));

  // A handshake in the limit cycle takes priority over the timeout
  assign timeout = (WAIT_MAX != 0) && (wait_cnt_q == WCNT_LIM) && !bus.mem_ready;

  logic mem_rd, mem_wr, oe_a, oe_b, ld_rf, inc_pc, ld_ir, ld_status;
  logic oe_mdr, ld_mdr, oe_mar, ld_mar, oe_alu;
  logic [REG_SEL_W-1:0] sel_a, sel_b, sel_ld;
  logic [ALU_OP_W-1:0]  alu_op;

  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    {mem_rd, mem_wr, oe_a, oe_b, ld_rf, inc_pc, ld_ir, ld_status} = '0;
    {oe_mdr, ld_mdr, oe_mar, ld_mar, oe_alu} = '0;
    sel_a  = '0;
    sel_b  = '0;
    sel_ld = '0;
    alu_op = '0;
    case (state_q)
      S_FETCH: begin
        sel_b = PC_SEL; oe_b = 1'b1; ld_mar = 1'b1;
        state_d = S_FETCH_W;
      end
      S_FETCH_W: begin
        oe_mar = 1'b1; mem_rd = 1'b1;
        if (bus.mem_ready) begin
          ld_ir = 1'b1; inc_pc = 1'b1;
          state_d = S_DECODE;
        end else if (timeout) begin
          state_d = S_HALTED; fault_d = 1'b1;
        end
      end
      S_DECODE: begin
        if (!pass) state_d = S_FETCH;
        else begin
          case (op)
            OP_NOP:        state_d = S_FETCH;
            OP_ALU:        state_d = S_EXEC;
            OP_LD, OP_ST:  state_d = S_MADDR;
            OP_HALT:       state_d = S_HALTED;
            default: begin state_d = S_HALTED; fault_d = 1'b1; end
          endcase
        end
      end
      S_EXEC: begin
        sel_a = ra; oe_a = 1'b1; sel_b = rb; oe_b = 1'b1;
        alu_op = aop; oe_alu = 1'b1; sel_ld = rd; ld_rf = 1'b1; ld_status = 1'b1;
        state_d = S_FETCH;
      end
      S_MADDR: begin
        sel_a = ra; oe_a = 1'b1; ld_mar = 1'b1;
        state_d = (op == OP_ST) ? S_SDATA : S_MRD_W;
      end
      S_MRD_W: begin
        oe_mar = 1'b1; mem_rd = 1'b1;
        if (bus.mem_ready) begin
          ld_mdr = 1'b1; state_d = S_WB;
        end else if (timeout) begin
          state_d = S_HALTED; fault_d = 1'b1;
        end
      end
      S_WB: begin
        oe_mdr = 1'b1; sel_ld = rd; ld_rf = 1'b1;
        state_d = S_FETCH;
      end
      S_SDATA: begin
        sel_b = rb; oe_b = 1'b1; ld_mdr = 1'b1;
        state_d = S_MWR_W;
      end
      S_MWR_W: begin
        oe_mar = 1'b1; oe_mdr = 1'b1; mem_wr = 1'b1;
        if (bus.mem_ready) state_d = S_FETCH;
        else if (timeout) begin
          state_d = S_HALTED; fault_d = 1'b1;
        end
      end
      S_HALTED: begin
        if (bus.run) begin
          state_d = S_FETCH; fault_d = 1'b0;
        end
      end
      default: state_d = S_FETCH;
    endcase

    wait_cnt_d = wait_cnt_q;
    if (state_d != state_q) wait_cnt_d = '0;
    else if (!bus.mem_ready) wait_cnt_d = wait_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_FETCH;
      fault_q    <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      fault_q    <= fault_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Outputs forced low while reset is held, including mid-access strobes
  assign bus.mem_rd          = rst_n & mem_rd;
  assign bus.mem_wr          = rst_n & mem_wr;
  assign bus.oe_a_reg_file   = rst_n & oe_a;
  assign bus.oe_b_reg_file   = rst_n & oe_b;
  assign bus.ld_reg_file     = rst_n & ld_rf;
  assign bus.sel_a_reg_file  = rst_n ? sel_a : '0;
  assign bus.sel_b_reg_file  = rst_n ? sel_b : '0;
  assign bus.sel_ld_reg_file = rst_n ? sel_ld : '0;
  assign bus.inc_pc          = rst_n & inc_pc;
  assign bus.ld_ir           = rst_n & ld_ir;
  assign bus.ld_status       = rst_n & ld_status;
  assign bus.oe_mdr          = rst_n & oe_mdr;
  assign bus.ld_mdr          = rst_n & ld_mdr;
  assign bus.oe_mar          = rst_n & oe_mar;
  assign bus.ld_mar          = rst_n & ld_mar;
  assign bus.oe_alu          = rst_n & oe_alu;
  assign bus.alu_op          = rst_n ? alu_op : '0;
  assign bus.halted          = rst_n & (state_q == S_HALTED);
  assign bus.fault           = rst_n & fault_q;

endmodule

// File: tb/tb_control_seq.sv
// Scoreboard bench for control_seq: each driven cycle pushes its expected output
// vector; a negedge monitor pops and compares against the DUT.
module tb_control_seq;

  typedef struct packed {
    logic       mem_rd, mem_wr, oe_a, oe_b, ld_rf;
    logic [3:0] sel_a, sel_b, sel_ld;
    logic       inc_pc, ld_ir, ld_status, oe_mdr, ld_mdr, oe_mar, ld_mar, oe_alu;
    logic [3:0] alu_op;
    logic       halted, fault;
  } out_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  control_seq_if #(.REG_SEL_W(4), .ALU_OP_W(4), .STATUS_W(4)) bus ();

  control_seq #(.NUM_REGS(16), .ALU_OP_W(4), .STATUS_W(4), .WAIT_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  out_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;
  logic [31:0] cur_ir = '0;
  logic [3:0]  cur_st = '0;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      out_t  e, a;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a = '{bus.mem_rd, bus.mem_wr, bus.oe_a_reg_file, bus.oe_b_reg_file, bus.ld_reg_file,
            bus.sel_a_reg_file, bus.sel_b_reg_file, bus.sel_ld_reg_file,
            bus.inc_pc, bus.ld_ir, bus.ld_status, bus.oe_mdr, bus.ld_mdr, bus.oe_mar,
            bus.ld_mar, bus.oe_alu, bus.alu_op, bus.halted, bus.fault};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got %h expected %h", nm, a, e);
      end
    end
  end

  function automatic logic [31:0] mk_ir(input logic [3:0] c, op, aop, rd, ra, rb);
    return {c, op, aop, rd, ra, rb, 8'h00};
  endfunction

  function automatic out_t x_zero();
    out_t o = '0;
    return o;
  endfunction
  function automatic out_t x_fetch();
    out_t o = '0;
    o.sel_b = 4'd15; o.oe_b = 1; o.ld_mar = 1;
    return o;
  endfunction
  function automatic out_t x_fetchw(input logic r);
    out_t o = '0;
    o.oe_mar = 1; o.mem_rd = 1; o.ld_ir = r; o.inc_pc = r;
    return o;
  endfunction
  function automatic out_t x_exec(input logic [3:0] aop, rd, ra, rb);
    out_t o = '0;
    o.sel_a = ra; o.oe_a = 1; o.sel_b = rb; o.oe_b = 1; o.alu_op = aop; o.oe_alu = 1;
    o.sel_ld = rd; o.ld_rf = 1; o.ld_status = 1;
    return o;
  endfunction
  function automatic out_t x_maddr(input logic [3:0] ra);
    out_t o = '0;
    o.sel_a = ra; o.oe_a = 1; o.ld_mar = 1;
    return o;
  endfunction
  function automatic out_t x_mrdw(input logic r);
    out_t o = '0;
    o.oe_mar = 1; o.mem_rd = 1; o.ld_mdr = r;
    return o;
  endfunction
  function automatic out_t x_wb(input logic [3:0] rd);
    out_t o = '0;
    o.oe_mdr = 1; o.sel_ld = rd; o.ld_rf = 1;
    return o;
  endfunction
  function automatic out_t x_sdata(input logic [3:0] rb);
    out_t o = '0;
    o.sel_b = rb; o.oe_b = 1; o.ld_mdr = 1;
    return o;
  endfunction
  function automatic out_t x_mwrw();
    out_t o = '0;
    o.oe_mar = 1; o.oe_mdr = 1; o.mem_wr = 1;
    return o;
  endfunction
  function automatic out_t x_halt(input logic f);
    out_t o = '0;
    o.halted = 1; o.fault = f;
    return o;
  endfunction

  task automatic step(input string nm, input logic rdy, input logic rn, input logic rs,
                      input out_t e);
    @(posedge clk);
    #1;
    rst_n         = rs;
    bus.ir        = cur_ir;
    bus.status    = cur_st;
    bus.mem_ready = rdy;
    bus.run       = rn;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic fetch_decode(input string nm);
    step({nm, "_fetch"},  1'b0, 1'b0, 1'b1, x_fetch());
    step({nm, "_fetchw"}, 1'b1, 1'b0, 1'b1, x_fetchw(1'b1));
    step({nm, "_decode"}, 1'b0, 1'b0, 1'b1, x_zero());
  endtask

  initial begin
    bus.ir = '0; bus.status = '0; bus.mem_ready = 1'b0; bus.run = 1'b0;

    step("reset_outputs", 1'b0, 1'b0, 1'b0, x_zero());

    // ALU r3 = r1 op6 r2, always
    cur_ir = mk_ir(4'h0, 4'h1, 4'h6, 4'd3, 4'd1, 4'd2);
    fetch_decode("alu");
    step("alu_exec", 1'b0, 1'b0, 1'b1, x_exec(4'h6, 4'd3, 4'd1, 4'd2));

    // LD r4 <- [r7], three wait cycles in each memory wait
    cur_ir = mk_ir(4'h0, 4'h2, 4'h0, 4'd4, 4'd7, 4'd0);
    step("ld_fetch", 1'b0, 1'b0, 1'b1, x_fetch());
    for (int i = 0; i < 3; i++) step("ld_fetchw_wait", 1'b0, 1'b0, 1'b1, x_fetchw(1'b0));
    step("ld_fetchw_rdy", 1'b1, 1'b0, 1'b1, x_fetchw(1'b1));
    step("ld_decode", 1'b0, 1'b0, 1'b1, x_zero());
    step("ld_maddr", 1'b0, 1'b0, 1'b1, x_maddr(4'd7));
    for (int i = 0; i < 3; i++) step("ld_mrdw_wait", 1'b0, 1'b0, 1'b1, x_mrdw(1'b0));
    step("ld_mrdw_rdy", 1'b1, 1'b0, 1'b1, x_mrdw(1'b1));
    step("ld_wb", 1'b0, 1'b0, 1'b1, x_wb(4'd4));

    // ST r2 -> [r5]
    cur_ir = mk_ir(4'h0, 4'h3, 4'h0, 4'd0, 4'd5, 4'd2);
    fetch_decode("st");
    step("st_maddr", 1'b0, 1'b0, 1'b1, x_maddr(4'd5));
    step("st_sdata", 1'b0, 1'b0, 1'b1, x_sdata(4'd2));
    step("st_mwrw_wait", 1'b0, 1'b0, 1'b1, x_mwrw());
    step("st_mwrw_wait", 1'b0, 1'b0, 1'b1, x_mwrw());
    step("st_mwrw_rdy", 1'b1, 1'b0, 1'b1, x_mwrw());

    // EQ with Z=0 skipped, then Z=1 executes
    cur_ir = mk_ir(4'h1, 4'h1, 4'h3, 4'd6, 4'd1, 4'd2);
    cur_st = 4'b0000;
    fetch_decode("eq_z0");
    cur_st = 4'b0100;
    fetch_decode("eq_z1");
    step("eq_z1_exec", 1'b0, 1'b0, 1'b1, x_exec(4'h3, 4'd6, 4'd1, 4'd2));

    // LT with N=1,V=0 executes; code B never executes
    cur_ir = mk_ir(4'hA, 4'h1, 4'h9, 4'd8, 4'd10, 4'd11);
    cur_st = 4'b1000;
    fetch_decode("lt");
    step("lt_exec", 1'b0, 1'b0, 1'b1, x_exec(4'h9, 4'd8, 4'd10, 4'd11));
    cur_ir = mk_ir(4'hB, 4'h1, 4'h9, 4'd8, 4'd10, 4'd11);
    fetch_decode("never");

    // HALT op: halted without fault, run ignored elsewhere, run resumes
    cur_ir = mk_ir(4'h0, 4'hF, 4'h0, 4'd0, 4'd0, 4'd0);
    cur_st = 4'b0000;
    fetch_decode("halt");
    step("halt_hold", 1'b1, 1'b0, 1'b1, x_halt(1'b0));
    step("halt_run", 1'b0, 1'b1, 1'b1, x_halt(1'b0));

    // Undefined op 5: halted with fault, cleared by run
    cur_ir = mk_ir(4'h0, 4'h5, 4'h0, 4'd0, 4'd0, 4'd0);
    fetch_decode("undef");
    step("undef_halt", 1'b0, 1'b0, 1'b1, x_halt(1'b1));
    step("undef_run", 1'b0, 1'b1, 1'b1, x_halt(1'b1));

    // Fetch timeout: four wait cycles then HALTED with fault
    cur_ir = mk_ir(4'h0, 4'h0, 4'h0, 4'd0, 4'd0, 4'd0);
    step("to_fetch", 1'b0, 1'b0, 1'b1, x_fetch());
    for (int i = 0; i < 4; i++) step("to_fetchw_wait", 1'b0, 1'b0, 1'b1, x_fetchw(1'b0));
    step("to_halt", 1'b1, 1'b0, 1'b1, x_halt(1'b1));
    step("to_run", 1'b0, 1'b1, 1'b1, x_halt(1'b1));

    // Reset during MWR_W
    cur_ir = mk_ir(4'h0, 4'h3, 4'h0, 4'd0, 4'd5, 4'd2);
    fetch_decode("rst_st");
    step("rst_st_maddr", 1'b0, 1'b0, 1'b1, x_maddr(4'd5));
    step("rst_st_sdata", 1'b0, 1'b0, 1'b1, x_sdata(4'd2));
    step("rst_st_mwrw", 1'b0, 1'b0, 1'b1, x_mwrw());
    step("rst_mid_access", 1'b0, 1'b0, 1'b0, x_zero());
    step("rst_release_fetch", 1'b0, 1'b0, 1'b1, x_fetch());
    step("rst_release_fetchw", 1'b0, 1'b0, 1'b1, x_fetchw(1'b0));

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
